// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the memory-mapped CORDIC engine.
package cordic_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_ANGLE  = 5'h08;
    localparam logic [4:0] OFF_COS    = 5'h0C;
    localparam logic [4:0] OFF_SIN    = 5'h10;

    localparam logic [31:0] CORDIC_K = 32'h26DD3B6A;

    // atan(2^-i) as binary angle, 2^32 = one turn
    localparam logic [31:0] ATAN [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    typedef enum logic {
        IDLE,
        ROT
    } state_t;

    localparam logic signed [33:0] SAT_MAX = 34'sd2147483647;
    localparam logic signed [33:0] SAT_MIN = -34'sd2147483648;

    function automatic logic [31:0] sat32(input logic signed [33:0] v);
        if (v > SAT_MAX) return 32'h7FFFFFFF;
        if (v < SAT_MIN) return 32'h80000000;
        return v[31:0];
    endfunction

endpackage

// File: rtl/cordic_bus_slave_core.sv
// Iterative rotation-mode CORDIC datapath: quadrant fold, x/y/z
// registers, iteration counter and the held cos/sin result.
module cordic_iter_core
    import cordic_pkg::*;
#(
    parameter int ITER = 24
) (
    input  logic        clk_gen,
    input  logic        srst,
    input  logic        start,
    input  logic [31:0] angle,
    output logic        busy,
    output logic        valid,
    output logic [31:0] cos,
    output logic [31:0] sin
);

    logic signed [33:0] x, y, z;
    logic signed [33:0] xn, yn, zn;
    logic signed [33:0] xs, ys, at;
    logic signed [33:0] xo, yo;
    logic [4:0]  cnt;
    logic        neg;
    logic        fold;
    logic [31:0] zf;

    // second and third quadrants are rotated by half a turn
    assign fold = angle[31] ^ angle[30];
    assign zf   = fold ? {~angle[31], angle[30:0]} : angle;

    assign xs = x >>> cnt;
    assign ys = y >>> cnt;
    assign at = $signed({2'b00, ATAN[cnt]});

    always_comb begin
        xn = x - ys;
        yn = y + xs;
        zn = z - at;
        if (z[33]) begin
            xn = x + ys;
            yn = y - xs;
            zn = z + at;
        end
    end

    assign xo    = neg ? -xn : xn;
    assign yo    = neg ? -yn : yn;
    assign valid = busy && (cnt == 5'(ITER - 1));

    always_ff @(posedge clk_gen) begin
        if (srst) begin
            x    <= '0;
            y    <= '0;
            z    <= '0;
            cnt  <= '0;
            neg  <= 1'b0;
            busy <= 1'b0;
            cos  <= '0;
            sin  <= '0;
        end else if (start && !busy) begin
            x    <= $signed({2'b00, CORDIC_K});
            y    <= '0;
            z    <= $signed({{2{zf[31]}}, zf});
            cnt  <= '0;
            neg  <= fold;
            busy <= 1'b1;
        end else if (busy) begin
            x   <= xn;
            y   <= yn;
            z   <= zn;
            cnt <= cnt + 5'd1;
            if (valid) begin
                busy <= 1'b0;
                cos  <= sat32(xo);
                sin  <= sat32(yo);
            end
        end
    end

endmodule

// File: rtl/cordic_bus_slave.sv
// Bus slave wrapper: register window decode, ANGLE/STATUS registers,
// start handshake and registered read responses for the CORDIC core.
module cordic_bus_slave
    import cordic_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h00000010,
    parameter int          ITER      = 24
) (
    input  logic        clk_gen,
    input  logic        srst,
    input  logic        bus_req_i,
    output logic        bus_ack_o,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        done_o
);

    state_t      state;
    logic [31:0] angle;
    logic        done;
    logic        busy;
    logic [31:0] off;
    logic        in_win;
    logic        wr_en, rd_en;
    logic        sel_ctrl, sel_stat, sel_ang, sel_cos, sel_sin;
    logic        start_cmd;
    logic        core_busy, core_valid;
    logic [31:0] core_cos, core_sin;
    logic [31:0] rd_val;

    assign bus_ack_o = bus_req_i;
    assign done_o    = done;
    assign busy      = (state == ROT);

    // wrapped subtraction keeps addresses below the base out of the window
    assign off    = bus_addr_bi - BASE_ADDR;
    assign in_win = (off[31:5] == '0);
    assign wr_en  = bus_req_i && bus_we_i && in_win;
    assign rd_en  = bus_req_i && !bus_we_i && in_win;

    assign sel_ctrl = (off[4:0] == OFF_CTRL);
    assign sel_stat = (off[4:0] == OFF_STATUS);
    assign sel_ang  = (off[4:0] == OFF_ANGLE);
    assign sel_cos  = (off[4:0] == OFF_COS);
    assign sel_sin  = (off[4:0] == OFF_SIN);

    assign start_cmd = wr_en && sel_ctrl && bus_be_bi[0]
                    && bus_wdata_bi[0] && (state == IDLE);

    cordic_iter_core #(
        .ITER (ITER)
    ) u_core (
        .clk_gen (clk_gen),
        .srst    (srst),
        .start   (start_cmd),
        .angle   (angle),
        .busy    (core_busy),
        .valid   (core_valid),
        .cos     (core_cos),
        .sin     (core_sin)
    );

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_stat: rd_val = {30'b0, done, busy};
            sel_ang:  rd_val = angle;
            sel_cos:  rd_val = core_cos;
            sel_sin:  rd_val = core_sin;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_gen) begin
        if (srst) begin
            state        <= IDLE;
            angle        <= '0;
            done         <= 1'b0;
            bus_resp_o   <= 1'b0;
            bus_rdata_bo <= '0;
        end else begin
            bus_resp_o   <= rd_en;
            bus_rdata_bo <= rd_en ? rd_val : '0;
            if (wr_en && sel_ang) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus_be_bi[b]) angle[8*b +: 8] <= bus_wdata_bi[8*b +: 8];
                end
            end
            unique case (state)
                IDLE: begin
                    if (start_cmd) begin
                        state <= ROT;
                        done  <= 1'b0;
                    end
                end
                ROT: begin
                    if (core_valid && core_busy) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_bus_slave.sv
// Directed bench for cordic_bus_slave: register access, timing, accuracy,
// ignored restart, window boundaries, byte enables and mid-run reset.
module tb_cordic_bus_slave;

    localparam logic [31:0] BASE = 32'h00000010;
    localparam int          ITER = 30;
    localparam int          TOL  = 48;

    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_ANG  = BASE + 32'h08;
    localparam logic [31:0] A_COS  = BASE + 32'h0C;
    localparam logic [31:0] A_SIN  = BASE + 32'h10;

    localparam logic [31:0] ONE    = 32'h40000000;
    localparam logic [31:0] M_ONE  = 32'hC0000000;
    localparam logic [31:0] C45    = 32'h2D413CCD;
    localparam logic [31:0] C30    = 32'h376CF5D1;
    localparam logic [31:0] S30    = 32'h20000000;
    localparam logic [31:0] DEG30  = 32'h15555555;
    localparam logic [31:0] DEG60  = 32'h2AAAAAAB;

    logic        clk_gen = 1'b0;
    logic        srst;
    logic        bus_req_i;
    logic        bus_ack_o;
    logic        bus_we_i;
    logic [31:0] bus_addr_bi;
    logic [3:0]  bus_be_bi;
    logic [31:0] bus_wdata_bi;
    logic        bus_resp_o;
    logic [31:0] bus_rdata_bo;
    logic        done_o;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk_gen = ~clk_gen;

    cordic_bus_slave #(
        .BASE_ADDR (BASE),
        .ITER      (ITER)
    ) dut (
        .clk_gen      (clk_gen),
        .srst         (srst),
        .bus_req_i    (bus_req_i),
        .bus_ack_o    (bus_ack_o),
        .bus_we_i     (bus_we_i),
        .bus_addr_bi  (bus_addr_bi),
        .bus_be_bi    (bus_be_bi),
        .bus_wdata_bi (bus_wdata_bi),
        .bus_resp_o   (bus_resp_o),
        .bus_rdata_bo (bus_rdata_bo),
        .done_o       (done_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp, input int tol);
        longint d;
        n_run++;
        d = longint'($signed(got)) - longint'($signed(exp));
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h tol %0d",
                     tag, got, exp, tol);
        end
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
        @(negedge clk_gen);
        bus_req_i    = 1'b1;
        bus_we_i     = 1'b1;
        bus_addr_bi  = addr;
        bus_be_bi    = be;
        bus_wdata_bi = data;
        @(negedge clk_gen);
        bus_req_i    = 1'b0;
        bus_we_i     = 1'b0;
        bus_be_bi    = 4'h0;
        bus_wdata_bi = '0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data,
                          output logic resp);
        @(negedge clk_gen);
        bus_req_i   = 1'b1;
        bus_we_i    = 1'b0;
        bus_addr_bi = addr;
        #1;
        check("ack", {31'b0, bus_ack_o}, 32'd1, 0);
        @(negedge clk_gen);
        bus_req_i = 1'b0;
        resp      = bus_resp_o;
        data      = bus_rdata_bo;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp, input int tol);
        logic [31:0] d;
        logic        r;
        bus_rd(addr, d, r);
        check({tag, ".resp"}, {31'b0, r}, 32'd1, 0);
        check(tag, d, exp, tol);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < ITER + 20) begin
            @(negedge clk_gen);
            n++;
        end
        check("done_wait", {31'b0, done_o}, 32'd1, 0);
    endtask

    task automatic run(input logic [31:0] ang);
        bus_wr(A_ANG, ang, 4'hF);
        bus_wr(A_CTRL, 32'd1, 4'hF);
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        r;

        srst         = 1'b1;
        bus_req_i    = 1'b0;
        bus_we_i     = 1'b0;
        bus_addr_bi  = '0;
        bus_be_bi    = 4'h0;
        bus_wdata_bi = '0;
        repeat (3) @(negedge clk_gen);
        srst = 1'b0;

        check("rst.done_o", {31'b0, done_o}, 32'd0, 0);
        check("rst.resp", {31'b0, bus_resp_o}, 32'd0, 0);
        rd_chk("rst.status", A_STAT, 32'd0, 0);
        rd_chk("rst.angle", A_ANG, 32'd0, 0);
        rd_chk("rst.cos", A_COS, 32'd0, 0);
        rd_chk("rst.sin", A_SIN, 32'd0, 0);

        // angle 0 with exact completion timing
        bus_wr(A_ANG, 32'd0, 4'hF);
        bus_wr(A_CTRL, 32'd1, 4'hF);
        check("t.start", {31'b0, done_o}, 32'd0, 0);
        repeat (ITER - 1) @(negedge clk_gen);
        check("t.pre", {31'b0, done_o}, 32'd0, 0);
        @(negedge clk_gen);
        check("t.done", {31'b0, done_o}, 32'd1, 0);
        rd_chk("a0.status", A_STAT, 32'd2, 0);
        rd_chk("a0.cos", A_COS, ONE, TOL);
        rd_chk("a0.sin", A_SIN, 32'd0, TOL);

        run(32'h20000000);
        rd_chk("a45.cos", A_COS, C45, TOL);
        rd_chk("a45.sin", A_SIN, C45, TOL);

        run(32'h80000000);
        rd_chk("a180.cos", A_COS, M_ONE, TOL);
        rd_chk("a180.sin", A_SIN, 32'd0, TOL);

        run(32'hC0000000);
        rd_chk("am90.cos", A_COS, 32'd0, TOL);
        rd_chk("am90.sin", A_SIN, M_ONE, TOL);

        // restart while busy is ignored; ANGLE still updates
        bus_wr(A_ANG, DEG30, 4'hF);
        bus_wr(A_CTRL, 32'd1, 4'hF);
        rd_chk("busy.status", A_STAT, 32'd1, 0);
        rd_chk("busy.cos_hold", A_COS, 32'd0, TOL);
        bus_wr(A_ANG, DEG60, 4'hF);
        bus_wr(A_CTRL, 32'd1, 4'hF);
        wait_done();
        rd_chk("a30.cos", A_COS, C30, TOL);
        rd_chk("a30.sin", A_SIN, S30, TOL);
        rd_chk("a30.angle", A_ANG, DEG60, 0);
        repeat (ITER + 5) @(negedge clk_gen);
        check("a30.no_restart", {31'b0, done_o}, 32'd1, 0);
        rd_chk("a30.status", A_STAT, 32'd2, 0);

        // window edges and read-only targets
        rd_chk("rd.ctrl", A_CTRL, 32'd0, 0);
        rd_chk("rd.0x1c", BASE + 32'h1C, 32'd0, 0);
        bus_rd(BASE + 32'h20, d, r);
        check("rd.0x20.resp", {31'b0, r}, 32'd0, 0);
        bus_rd(BASE - 32'h4, d, r);
        check("rd.below.resp", {31'b0, r}, 32'd0, 0);
        bus_wr(A_COS, 32'h12345678, 4'hF);
        rd_chk("ro.cos", A_COS, C30, TOL);
        bus_wr(A_CTRL, 32'd1, 4'b1110);
        @(negedge clk_gen);
        check("ctrl.be0", {31'b0, done_o}, 32'd1, 0);

        // byte enables on ANGLE
        bus_wr(A_ANG, 32'd0, 4'hF);
        bus_wr(A_ANG, 32'hFFFFFFFF, 4'b0001);
        rd_chk("be.0001", A_ANG, 32'h000000FF, 0);
        bus_wr(A_ANG, 32'hAABBCCDD, 4'b0100);
        rd_chk("be.0100", A_ANG, 32'h00BB00FF, 0);

        // reset in the middle of a rotation
        bus_wr(A_ANG, 32'h20000000, 4'hF);
        bus_wr(A_CTRL, 32'd1, 4'hF);
        repeat (10) @(negedge clk_gen);
        srst = 1'b1;
        @(negedge clk_gen);
        srst = 1'b0;
        check("srst.done_o", {31'b0, done_o}, 32'd0, 0);
        rd_chk("srst.status", A_STAT, 32'd0, 0);
        rd_chk("srst.cos", A_COS, 32'd0, 0);
        rd_chk("srst.sin", A_SIN, 32'd0, 0);
        rd_chk("srst.angle", A_ANG, 32'd0, 0);
        repeat (ITER) @(negedge clk_gen);
        check("srst.idle", {31'b0, done_o}, 32'd0, 0);
        run(32'h20000000);
        rd_chk("post.cos", A_COS, C45, TOL);
        rd_chk("post.sin", A_SIN, C45, TOL);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
